frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Parametrised frame-level controller for the sand simulation. It launches one cell-update pass of the next-state engine per frame and paces frames to a programmable period. It publishes the result to the display either by copying the work RAM into VRAM or by flipping a double-buffer bank select. It adds pause/single-step, a VRAM clear sequence, overrun detection and a frame counter, and sits between the cell engine, the work RAM and the VRAM/VGA path.

## Interface
Parameters:
- ACTIVE_COLUMNS, 640, cells per row
- ACTIVE_ROWS, 480, rows
- DATA_WIDTH, 2, bits per cell (cell type)
- TICK_WIDTH, 27, width of frame-period counter
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), derived; not overridden

Ports:
- clk_i  in  1  system clock; single clock domain
- reset_n_i  in  1  asynchronous, active-low reset
- enable_i  in  1  free-run frames while high
- step_i  in  1  one-cycle pulse; run exactly one frame while paused
- clear_i  in  1  one-cycle pulse; request VRAM clear
- swap_mode_i  in  1  0 = copy publish, 1 = bank-swap publish; sampled at frame start
- period_i  in  TICK_WIDTH  frame period in cycles; 0 is treated as 1
- engine_start_o  out  1  one-cycle start pulse to cell engine
- engine_done_i  in  1  one-cycle pulse when engine pass completes
- ram_rd_address_o  out  ADDR_WIDTH  work-RAM read address (copy phase)
- ram_rd_data_i  in  DATA_WIDTH  work-RAM data, 1-cycle synchronous read latency
- vram_wr_address_o  out  ADDR_WIDTH  VRAM write address
- vram_wr_data_o  out  DATA_WIDTH  VRAM write data
- vram_wr_en_o  out  1  VRAM write strobe
- bank_sel_o  out  1  display bank (swap mode)
- busy_o  out  1  high in any state except IDLE
- overrun_o  out  1  sticky: engine finished after the period expired
- frame_count_o  out  16  completed frames, wraps at 2^16

## Operation
- N = ACTIVE_COLUMNS*ACTIVE_ROWS. States: IDLE, COMPUTE, WAIT, COPY, SWAP, CLEAR.
- IDLE: a pending clear has priority and goes to CLEAR. Otherwise, enable_i=1 or step_i=1 goes to COMPUTE and latches swap_mode_i. Else stay.
- COMPUTE: engine_start_o=1 in the first cycle only. On engine_done_i: if tick ≥ period-1, set overrun_o and go directly to publish; else go to WAIT.
- WAIT: on tick ≥ period-1, go to publish (COPY if latched mode 0, SWAP if 1).
- COPY: read addresses 0..N-1 on consecutive cycles. VRAM write of address a occurs one cycle after its read, with data = ram_rd_data_i. Lasts N+1 cycles. Then frame_count += 1 and go to IDLE.
- SWAP: one cycle; toggle bank_sel_o; frame_count += 1; go to IDLE.
- CLEAR: write 0 to VRAM addresses 0..N-1, one per cycle (N cycles). Clear overrun_o and the clear request, then go to IDLE.
- clear_i at any time sets a pending flag, serviced at the next IDLE. It never aborts a frame in progress.
- enable_i dropping mid-frame: the current frame completes; the sequencer then stays in IDLE.
- step_i is ignored outside IDLE and while enable_i=1.
- The engine writes every cell of the work RAM each pass; the sequencer never writes RAM.

## Timing
- Reset (reset_n_i low, asynchronous): state IDLE, all counters 0, engine_start_o=0, vram_wr_en_o=0, vram_wr_address_o=0, vram_wr_data_o=0, ram_rd_address_o=0, bank_sel_o=0, busy_o=0, overrun_o=0, frame_count_o=0, clear pending=0.
- Reset mid-COPY or mid-CLEAR aborts immediately. No partial-write recovery is required.
- The tick counter is 0 in the engine_start_o cycle and increments by 1 each cycle, saturating at all-ones.
- The cycle-count from the engine_start_o cycle to the first COPY/SWAP cycle is max(period, done_cycle+1).
- IDLE→COMPUTE takes 1 cycle, so back-to-back frames incur one IDLE cycle.
- All outputs are registered. vram_wr_en_o is never high in IDLE, COMPUTE, WAIT or SWAP.
- Address counters are ADDR_WIDTH bits. Comparison against N-1 is done at full width, with no wrap past N-1.

## Structure
- Package sand_pkg: the state enum frame_state_t, cell type constants (CELL_EMPTY=0, CELL_SAND, CELL_WALL), and publish-mode constants.
- Sub-module frame_copier: an address sweep 0..N-1 with a 1-cycle delayed write and a data-select (RAM data or zero). It is shared by COPY and CLEAR and handshakes via start/done.

## Test plan
Use 4×2 grid (N=8), DATA_WIDTH=2.
- Copy mode, period=20, engine_done_i at tick 5 → engine_start_o once; first COPY cycle at tick 20; VRAM writes addr 0..7 with RAM data, each 1 cycle after its read; frame_count_o=1.
- Engine done at tick 30, period=20 → overrun_o=1; COPY starts the next cycle; clear_i later → overrun_o=0.
- Swap mode, 3 frames → no vram_wr_en_o; bank_sel_o toggles 0→1→0→1; frame_count_o=3.
- enable_i=0, step_i pulse → exactly one frame, busy_o then low; step_i during busy → ignored.
- clear_i mid-WAIT → frame completes; then 8 VRAM writes of 0 to addr 0..7; then IDLE.
- reset_n_i low mid-COPY (addr 3) → all outputs take reset values asynchronously; restart copies from addr 0.

Source files
------------

// File: rtl/sand_pkg.sv
// Shared types and constants for the sand simulation frame path.
package sand_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_WAIT,
        ST_COPY,
        ST_SWAP,
        ST_CLEAR
    } frame_state_t;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_SAND  = 2'd1;
    localparam logic [1:0] CELL_WALL  = 2'd2;

    localparam logic PUBLISH_COPY = 1'b0;
    localparam logic PUBLISH_SWAP = 1'b1;

endpackage

// File: rtl/frame_copier.sv
// Address sweep 0..CELLS-1 feeding VRAM one cycle behind the RAM read,
// writing either the RAM read data or zeros (clear).
module frame_copier #(
    parameter int CELLS      = 8,
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = $clog2(CELLS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  zero_fill,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_address,
    output logic [ADDR_WIDTH-1:0] wr_address,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CELLS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] rd_addr_p0;
    logic                  sweep_p0;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic                  wr_en_p1;
    logic                  zero_p1;

    // A clear has no read to wait for, so it treats address 0 as already
    // swept and writes it in its first cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_p0 <= '0;
            sweep_p0   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_en_p1   <= 1'b0;
            zero_p1    <= 1'b0;
        end else if (start) begin
            zero_p1 <= zero_fill;
            if (zero_fill) begin
                wr_en_p1   <= 1'b1;
                wr_addr_p1 <= '0;
                sweep_p0   <= (CELLS > 1);
                rd_addr_p0 <= (CELLS > 1) ? ONE : '0;
            end else begin
                wr_en_p1   <= 1'b0;
                sweep_p0   <= 1'b1;
                rd_addr_p0 <= '0;
            end
        end else begin
            // read stage p0 -> write stage p1
            wr_en_p1 <= sweep_p0;
            if (sweep_p0) begin
                wr_addr_p1 <= rd_addr_p0;
                if (rd_addr_p0 == LAST) begin
                    sweep_p0   <= 1'b0;
                    rd_addr_p0 <= '0;
                end else begin
                    rd_addr_p0 <= rd_addr_p0 + ONE;
                end
            end
        end
    end

    assign rd_address = rd_addr_p0;
    assign wr_address = wr_addr_p1;
    assign wr_en      = wr_en_p1;
    // The RAM output register already aligns its data with wr_en_p1.
    assign wr_data    = (wr_en_p1 && !zero_p1) ? rd_data : '0;
    assign done       = wr_en_p1 && (wr_addr_p1 == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Frame-level controller: paces engine passes to a period and publishes
// each frame by VRAM copy or bank swap, with clear, pause/step and overrun.
module frame_sequencer
    import sand_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int DATA_WIDTH     = 2,
    parameter int TICK_WIDTH     = 27,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  enable_i,
    input  logic                  step_i,
    input  logic                  clear_i,
    input  logic                  swap_mode_i,
    input  logic [TICK_WIDTH-1:0] period_i,
    output logic                  engine_start_o,
    input  logic                  engine_done_i,
    output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
    output logic [DATA_WIDTH-1:0] vram_wr_data_o,
    output logic                  vram_wr_en_o,
    output logic                  bank_sel_o,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic [15:0]           frame_count_o
);

    localparam int CELLS = ACTIVE_COLUMNS * ACTIVE_ROWS;

    frame_state_t          state;
    frame_state_t          state_next;
    frame_state_t          publish_state;
    logic                  mode_swap;
    logic                  clear_pend;
    logic [TICK_WIDTH-1:0] tick;
    logic [TICK_WIDTH-1:0] tick_limit;
    logic                  period_reached;
    logic                  start_next;
    logic                  busy_next;
    logic                  copier_start;
    logic                  zero_fill;
    logic                  copier_done;

    // A period of 0 behaves like 1.
    assign tick_limit     = (period_i == '0) ? '0 : period_i - TICK_WIDTH'(1);
    assign period_reached = (tick >= tick_limit);
    assign publish_state  = (mode_swap == PUBLISH_SWAP) ? ST_SWAP : ST_COPY;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= ST_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (clear_pend)              state_next = ST_CLEAR;
                else if (enable_i || step_i) state_next = ST_COMPUTE;
            end
            ST_COMPUTE: if (engine_done_i)  state_next = period_reached ? publish_state : ST_WAIT;
            ST_WAIT:    if (period_reached) state_next = publish_state;
            ST_COPY:    if (copier_done)    state_next = ST_IDLE;
            ST_SWAP:                        state_next = ST_IDLE;
            ST_CLEAR:   if (copier_done)    state_next = ST_IDLE;
            default:                        state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        start_next   = (state == ST_IDLE) && (state_next == ST_COMPUTE);
        busy_next    = (state_next != ST_IDLE);
        zero_fill    = (state_next == ST_CLEAR);
        copier_start = ((state != ST_COPY)  && (state_next == ST_COPY)) ||
                       ((state != ST_CLEAR) && (state_next == ST_CLEAR));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            engine_start_o <= 1'b0;
            busy_o         <= 1'b0;
            tick           <= '0;
            mode_swap      <= PUBLISH_COPY;
            overrun_o      <= 1'b0;
            clear_pend     <= 1'b0;
            bank_sel_o     <= 1'b0;
            frame_count_o  <= '0;
        end else begin
            engine_start_o <= start_next;
            busy_o         <= busy_next;
            if (start_next) begin
                tick      <= '0;
                mode_swap <= swap_mode_i;
            end else if (tick != '1) begin
                tick <= tick + TICK_WIDTH'(1);
            end
            if (state == ST_COMPUTE && engine_done_i && period_reached)
                overrun_o <= 1'b1;
            else if (state == ST_CLEAR && copier_done)
                overrun_o <= 1'b0;
            // A fresh request arriving during a clear survives its completion.
            if (clear_i)
                clear_pend <= 1'b1;
            else if (state == ST_CLEAR && copier_done)
                clear_pend <= 1'b0;
            if (state == ST_SWAP)
                bank_sel_o <= ~bank_sel_o;
            if (state == ST_SWAP || (state == ST_COPY && copier_done))
                frame_count_o <= frame_count_o + 16'd1;
        end
    end

    frame_copier #(
        .CELLS      (CELLS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_copier (
        .clk        (clk_i),
        .reset_n    (reset_n_i),
        .start      (copier_start),
        .zero_fill  (zero_fill),
        .rd_data    (ram_rd_data_i),
        .rd_address (ram_rd_address_o),
        .wr_address (vram_wr_address_o),
        .wr_data    (vram_wr_data_o),
        .wr_en      (vram_wr_en_o),
        .done       (copier_done)
    );

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4x2 grid with a behavioural
// work RAM and a cell engine that answers after a programmable delay.
module tb_frame_sequencer;
    import sand_pkg::*;

    localparam int TW = 27;
    localparam int AW = 3;
    localparam int DW = 2;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          step = 1'b0;
    logic          clear = 1'b0;
    logic          swap_mode = 1'b0;
    logic [TW-1:0] period = 20;
    logic          engine_start;
    logic          engine_done = 1'b0;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data = '0;
    logic [AW-1:0] vram_wr_addr;
    logic [DW-1:0] vram_wr_data;
    logic          vram_wr_en;
    logic          bank_sel;
    logic          busy;
    logic          overrun;
    logic [15:0]   frame_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_tick = 5;
    int n_start = 0;

    logic [DW-1:0] mem [0:N-1];
    int            wr_cyc  [$];
    logic [AW-1:0] wr_addr [$];
    logic [DW-1:0] wr_data [$];

    frame_sequencer #(
        .ACTIVE_COLUMNS (4),
        .ACTIVE_ROWS    (2),
        .DATA_WIDTH     (DW),
        .TICK_WIDTH     (TW)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .enable_i          (enable),
        .step_i            (step),
        .clear_i           (clear),
        .swap_mode_i       (swap_mode),
        .period_i          (period),
        .engine_start_o    (engine_start),
        .engine_done_i     (engine_done),
        .ram_rd_address_o  (ram_rd_addr),
        .ram_rd_data_i     (ram_rd_data),
        .vram_wr_address_o (vram_wr_addr),
        .vram_wr_data_o    (vram_wr_data),
        .vram_wr_en_o      (vram_wr_en),
        .bank_sel_o        (bank_sel),
        .busy_o            (busy),
        .overrun_o         (overrun),
        .frame_count_o     (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        ram_rd_data <= mem[ram_rd_addr];
    end

    always @(negedge clk) begin
        if (vram_wr_en) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(vram_wr_addr);
            wr_data.push_back(vram_wr_data);
        end
    end

    // Engine model: done pulse arrives done_tick cycles after the start cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (engine_start && reset_n) begin
                n_start++;
                if (done_tick > 0) repeat (done_tick) @(negedge clk);
                engine_done = 1'b1;
                @(negedge clk);
                engine_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic wait_start(output int start_c, output bit ok);
        start_c = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (engine_start) begin
                start_c = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({engine_start, vram_wr_en, busy, overrun, bank_sel} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {engine_start, vram_wr_en, busy, overrun, bank_sel});
        end
        checks++;
        if (frame_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
        end
        checks++;
        if ({vram_wr_addr, ram_rd_addr, vram_wr_data} !== '0) begin
            failures++;
            $display("FAIL reset_buses: got wa=%0d ra=%0d wd=%0d expected 0",
                     vram_wr_addr, ram_rd_addr, vram_wr_data);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_copy_frame();
        int sc;
        int s0;
        bit ok;
        mem = '{CELL_SAND, CELL_WALL, CELL_EMPTY, CELL_SAND,
                CELL_WALL, CELL_WALL, CELL_EMPTY, CELL_SAND};
        period = 20;
        done_tick = 5;
        swap_mode = 1'b0;
        clear_log();
        s0 = n_start;
        @(negedge clk);
        enable = 1'b1;
        wait_start(sc, ok);
        enable = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL copy_start: no engine_start seen, required 1"); end
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL copy_idle: busy stuck high, required low"); end
        checks++;
        if (n_start - s0 != 1) begin
            failures++;
            $display("FAIL copy_start_count: got %0d expected 1", n_start - s0);
        end
        checks++;
        if (wr_addr.size() != N) begin
            failures++;
            $display("FAIL copy_write_count: got %0d expected %0d", wr_addr.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (wr_addr[i] !== AW'(i) || wr_data[i] !== mem[i] || wr_cyc[i] != sc + 21 + i) begin
                    failures++;
                    $display("FAIL copy_write[%0d]: got a=%0d d=%0d c=%0d expected a=%0d d=%0d c=%0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i] - sc, i, mem[i], 21 + i);
                end
            end
        end
        checks++;
        if (frame_count !== 16'd1 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL copy_status: got fc=%0d ov=%b expected fc=1 ov=0", frame_count, overrun);
        end
    endtask

    task automatic test_overrun_clear();
        int sc;
        bit ok;
        done_tick = 30;
        period = 20;
        clear_log();
        @(negedge clk);
        enable = 1'b1;
        wait_start(sc, ok);
        enable = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got ov=%b idle=%b expected ov=1 idle=1", overrun, ok);
        end
        checks++;
        if (wr_cyc.size() != N || wr_cyc[0] != sc + 32) begin
            failures++;
            $display("FAIL overrun_copy_timing: got n=%0d first=%0d expected n=%0d first=32",
                     wr_cyc.size(), (wr_cyc.size() > 0) ? wr_cyc[0] - sc : -1, N);
        end
        checks++;
        if (frame_count !== 16'd2) begin
            failures++;
            $display("FAIL overrun_frame_count: got %0d expected 2", frame_count);
        end
        clear_log();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_status: got ov=%b busy=%b expected ov=0 busy=0", overrun, busy);
        end
        checks++;
        if (wr_addr.size() != N) begin
            failures++;
            $display("FAIL clear_write_count: got %0d expected %0d", wr_addr.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (wr_addr[i] !== AW'(i) || wr_data[i] !== CELL_EMPTY || wr_cyc[i] != wr_cyc[0] + i) begin
                    failures++;
                    $display("FAIL clear_write[%0d]: got a=%0d d=%0d dc=%0d expected a=%0d d=0 dc=%0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i] - wr_cyc[0], i, i);
                end
            end
        end
        checks++;
        if (frame_count !== 16'd2) begin
            failures++;
            $display("FAIL clear_frame_count: got %0d expected 2", frame_count);
        end
    endtask

    task automatic test_back_to_back_swap();
        int sc [3];
        int s0;
        bit ok;
        swap_mode = 1'b1;
        period = 4;
        done_tick = 1;
        clear_log();
        s0 = n_start;
        @(negedge clk);
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_start(sc[f], ok);
            checks++;
            if (!ok || bank_sel !== f[0]) begin
                failures++;
                $display("FAIL swap_bank_at_start[%0d]: got %b seen=%b expected %b", f, bank_sel, ok, f[0]);
            end
        end
        enable = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || bank_sel !== 1'b1) begin
            failures++;
            $display("FAIL swap_bank_final: got %b expected 1", bank_sel);
        end
        checks++;
        if (frame_count !== 16'd5 || n_start - s0 != 3) begin
            failures++;
            $display("FAIL swap_frames: got fc=%0d starts=%0d expected fc=5 starts=3",
                     frame_count, n_start - s0);
        end
        checks++;
        if (wr_addr.size() != 0) begin
            failures++;
            $display("FAIL swap_no_writes: got %0d writes expected 0", wr_addr.size());
        end
        checks++;
        if (sc[1] - sc[0] != 6 || sc[2] - sc[1] != 6) begin
            failures++;
            $display("FAIL swap_spacing: got %0d,%0d expected 6,6", sc[1] - sc[0], sc[2] - sc[1]);
        end
    endtask

    task automatic test_step();
        int sc;
        int s0;
        bit ok;
        enable = 1'b0;
        s0 = n_start;
        @(negedge clk);
        step = 1'b1;
        wait_start(sc, ok);
        step = 1'b0;
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL step_start: got seen=%b busy=%b expected seen=1 busy=1", ok, busy);
        end
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_idle(ok);
        repeat (10) @(negedge clk);
        checks++;
        if (n_start - s0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL step_single: got starts=%0d busy=%b expected starts=1 busy=0", n_start - s0, busy);
        end
        checks++;
        if (frame_count !== 16'd6 || bank_sel !== 1'b0) begin
            failures++;
            $display("FAIL step_status: got fc=%0d bank=%b expected fc=6 bank=0", frame_count, bank_sel);
        end
    endtask

    task automatic test_clear_mid_wait();
        int sc;
        bit ok;
        swap_mode = 1'b0;
        period = 20;
        done_tick = 2;
        clear_log();
        @(negedge clk);
        enable = 1'b1;
        wait_start(sc, ok);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (wr_addr.size() != 2 * N) begin
            failures++;
            $display("FAIL midwait_write_count: got %0d expected %0d", wr_addr.size(), 2 * N);
        end else begin
            for (int i = 0; i < 2 * N; i++) begin
                logic [DW-1:0] ed;
                int ec;
                ed = (i < N) ? mem[i] : CELL_EMPTY;
                ec = (i < N) ? sc + 21 + i : sc + 22 + i;
                checks++;
                if (wr_addr[i] !== AW'(i % N) || wr_data[i] !== ed || wr_cyc[i] != ec) begin
                    failures++;
                    $display("FAIL midwait_write[%0d]: got a=%0d d=%0d c=%0d expected a=%0d d=%0d c=%0d",
                             i, wr_addr[i], wr_data[i], wr_cyc[i] - sc, i % N, ed, ec - sc);
                end
            end
        end
        checks++;
        if (frame_count !== 16'd7 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midwait_status: got fc=%0d busy=%b ov=%b expected fc=7 busy=0 ov=0",
                     frame_count, busy, overrun);
        end
    endtask

    task automatic test_reset_mid_copy();
        int sc;
        bit ok;
        bit hit;
        mem = '{CELL_WALL, CELL_SAND, CELL_SAND, CELL_WALL,
                CELL_EMPTY, CELL_SAND, CELL_WALL, CELL_EMPTY};
        period = 20;
        done_tick = 5;
        clear_log();
        @(negedge clk);
        enable = 1'b1;
        wait_start(sc, ok);
        enable = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (vram_wr_en && vram_wr_addr == AW'(3)) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL rst_copy_reach: addr 3 write not seen, required 1"); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({engine_start, vram_wr_en, vram_wr_addr, vram_wr_data, ram_rd_addr, bank_sel, busy, overrun} !== '0) begin
            failures++;
            $display("FAIL rst_async_outputs: got en=%b wa=%0d wd=%0d ra=%0d busy=%b expected all 0",
                     vram_wr_en, vram_wr_addr, vram_wr_data, ram_rd_addr, busy);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_async_frame_count: got %0d expected 0", frame_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        @(negedge clk);
        enable = 1'b1;
        wait_start(sc, ok);
        enable = 1'b0;
        wait_idle(ok);
        checks++;
        if (wr_addr.size() != N) begin
            failures++;
            $display("FAIL rst_restart_count: got %0d expected %0d", wr_addr.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (wr_addr[i] !== AW'(i) || wr_data[i] !== mem[i]) begin
                    failures++;
                    $display("FAIL rst_restart_write[%0d]: got a=%0d d=%0d expected a=%0d d=%0d",
                             i, wr_addr[i], wr_data[i], i, mem[i]);
                end
            end
        end
        checks++;
        if (frame_count !== 16'd1) begin
            failures++;
            $display("FAIL rst_restart_frame_count: got %0d expected 1", frame_count);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = CELL_EMPTY;
        test_reset();
        test_copy_frame();
        test_overrun_clear();
        test_back_to_back_swap();
        test_step();
        test_clear_mid_wait();
        test_reset_mid_copy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
